// File: rtl/mem_pkg.sv
// Shared definitions for the sized data memory: RISC-V load/store size codes
// and the request-sequencing state type.
package mem_pkg;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_lane_format.sv
// Byte-lane steering for one aligned 32-bit word: load extraction/extension,
// store lane mask and replicated write data, plus size/alignment error decode.
module mem_lane_format
    import mem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic        err,
    output logic [31:0] rdata,
    output logic [3:0]  wr_mask,
    output logic [31:0] wr_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [3:0]  lane_mask;

    always_comb begin
        ld_byte   = rd_word[8*addr_lo +: 8];
        ld_half   = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        err       = 1'b0;
        ld_ext    = 32'd0;
        lane_mask = 4'b0000;
        wr_word   = 32'd0;
        case (size)
            SIZE_B: begin
                ld_ext    = {{24{ld_byte[7]}}, ld_byte};
                lane_mask = 4'b0001 << addr_lo;
                wr_word   = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                err       = addr_lo[0];
                ld_ext    = {{16{ld_half[15]}}, ld_half};
                lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_word   = {2{wdata[15:0]}};
            end
            SIZE_W: begin
                err       = (addr_lo != 2'b00);
                ld_ext    = rd_word;
                lane_mask = 4'b1111;
                wr_word   = wdata;
            end
            // Unsigned sizes only make sense for loads
            SIZE_BU: begin
                err    = we;
                ld_ext = {24'd0, ld_byte};
            end
            SIZE_HU: begin
                err    = we | addr_lo[0];
                ld_ext = {16'd0, ld_half};
            end
            default: err = 1'b1;
        endcase
        rdata   = (err || we) ? 32'd0 : ld_ext;
        wr_mask = (err || !we) ? 4'b0000 : lane_mask;
    end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressed data memory with RISC-V sized loads/stores, a fixed access
// latency and a valid/ready request/response handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a request (req_ready=1)
//   ST_WAIT | request captured, latency counter running down to 0
//   ST_RESP | response held on resp_* until resp_ready
module sized_data_memory
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e          state;
    logic [CW-1:0]   cnt;
    logic            r_we;
    logic [2:0]      r_size;
    logic [AW-1:0]   r_addr;
    logic [31:0]     r_wdata;

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   base;
    logic [31:0]     rd_word;
    logic            access;
    logic            fmt_err;
    logic [31:0]     fmt_rdata;
    logic [3:0]      wr_mask;
    logic [31:0]     wr_word;
    logic            unused_addr;

    // Address bits above the memory size wrap around and are intentionally dropped
    assign unused_addr = ^req_addr[ADDR_W-1:AW];

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign access     = (state == ST_WAIT) && (cnt == '0);

    assign base    = r_addr & ~AW'(3);
    assign rd_word = {mem[base | AW'(3)], mem[base | AW'(2)],
                      mem[base | AW'(1)], mem[base]};

    mem_lane_format u_lane (
        .we      (r_we),
        .size    (r_size),
        .addr_lo (r_addr[1:0]),
        .rd_word (rd_word),
        .wdata   (r_wdata),
        .err     (fmt_err),
        .rdata   (fmt_rdata),
        .wr_mask (wr_mask),
        .wr_word (wr_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            r_we       <= 1'b0;
            r_size     <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_addr  <= req_addr[AW-1:0];
                        r_wdata <= req_wdata;
                        cnt     <= CW'(LATENCY - 1);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        resp_rdata <= fmt_rdata;
                        resp_err   <= fmt_err;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage is never reset; reset forces IDLE so a pending store cannot commit
    always_ff @(posedge clk) begin
        if (access) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) mem[base | AW'(i)] <= wr_word[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/sized_data_memory.md
SIZED_DATA_MEMORY -- requirements
Module: sized_data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 256, memory size in bytes (power of two, >=4).
REQ-002 SHALL have parameter ADDR_W, default 32, request address width.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request accept to resp_valid (>=1).
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, block can accept a request.
REQ-008 SHALL have port req_we, input, 1, 1=store, 0=load.
REQ-009 SHALL have port req_size, input, 3, RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-011 SHALL have port req_wdata, input, 32, store data, least-significant bytes used.
REQ-012 SHALL have port resp_valid, output, 1, response present.
REQ-013 SHALL have port resp_ready, input, 1, consumer accepts response.
REQ-014 SHALL have port resp_rdata, output, 32, load result, extended per size.
REQ-015 SHALL have port resp_err, output, 1, request was misaligned or had an illegal size.

Function
REQ-016 SHALL implement states IDLE, WAIT and RESP; req_ready=1 only in IDLE.
REQ-017 SHALL accept a request on an edge where state=IDLE and req_valid=1, registering we/size/addr/wdata; later input changes SHALL be ignored.
REQ-018 SHALL go from IDLE to WAIT, load counter with LATENCY-1, decrement each cycle, and enter RESP on the edge where the counter is 0 (LATENCY=1: WAIT lasts one cycle).
REQ-019 SHALL perform the memory access (store commit or load sample) only on the edge entering RESP.
REQ-020 SHALL hold resp_valid=1, resp_rdata and resp_err stable in RESP until an edge with resp_ready=1, then return to IDLE; no new request accepted on that edge.
REQ-021 SHALL index memory with req_addr[log2(DEPTH)-1:0], little-endian; upper address bits ignored (wrap-around).
REQ-022 SHALL flag an error for H/HU with addr[0]=1, W with addr[1:0]!=0, or size 011/110/111.
REQ-023 SHALL skip the memory access on an errored request, return resp_err=1 and resp_rdata=0, and keep the normal latency.
REQ-024 SHALL sign-extend loads for B/H, zero-extend for BU/HU, and return the full word for W.
REQ-025 SHALL write only the addressed 1/2/4 bytes on a store; BU/HU sizes on a store are illegal (error).
REQ-026 SHALL drive resp_rdata=0 for stores.
REQ-027 SHALL drive resp_rdata=0 and resp_err=0 whenever resp_valid=0.

Reset
REQ-028 SHALL on rst=1, immediately and independent of clk, force state IDLE, counter 0, req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-029 SHALL NOT reset memory contents; power-up contents are undefined.
REQ-030 SHALL discard a store whose request was accepted but has not reached RESP when reset asserts; memory stays unchanged.

Structure
REQ-031 SHALL place size-code localparams and the state enum in shared package mem_pkg.
REQ-032 SHALL use one combinational sub-module, mem_lane_format, for byte-lane extraction, extension and error decode.

Verification
REQ-033 SHALL verify: SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata 0xDEADBEEF, resp_valid exactly 2 cycles after accept, err=0.
REQ-034 SHALL verify: after REQ-033 data, LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-035 SHALL verify: SW @0x11 or LH @0x01 -> resp_err=1, rdata=0; word @0x10 unchanged.
REQ-036 SHALL verify: with resp_ready=0 for 5 cycles, resp_valid/rdata stay stable and req_ready=0; request presented meanwhile is not accepted.
REQ-037 SHALL verify: SB 0x55 @0x20 with rst pulsed during WAIT -> outputs at reset values immediately; subsequent LBU @0x20 shows old byte.
REQ-038 SHALL verify: DEPTH=256, SW 0x12345678 @0x104, then LW @0x004 -> 0x12345678 (wrap-around).
